// File: rtl/acc_seq_if.sv
// acc_seq_if: opcode/flag/handshake inputs and strobe outputs of the accumulator sequencer.
interface acc_seq_if #(parameter int OP_W = 3);
  logic [OP_W-1:0] op;
  logic z_flag, mem_ready;
  logic PC_bus, ACC_bus, MDR_bus, Addr_bus;
  logic load_PC, INC_PC, load_IR, load_MAR, load_MDR, load_ACC;
  logic ALU_ACC, ALU_add, ALU_sub, ALU_xor;
  logic CS, R_NW, halted;
  modport master (
    input  op, z_flag, mem_ready,
    output PC_bus, ACC_bus, MDR_bus, Addr_bus, load_PC, INC_PC, load_IR, load_MAR,
           load_MDR, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, CS, R_NW, halted
  );
  modport slave (
    output op, z_flag, mem_ready,
    input  PC_bus, ACC_bus, MDR_bus, Addr_bus, load_PC, INC_PC, load_IR, load_MAR,
           load_MDR, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, CS, R_NW, halted
  );
endinterface

// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle fetch/decode/execute control FSM for the 8-bit accumulator datapath.
module acc_sequencer #(parameter int OP_W = 3) (
  input logic clock,
  input logic n_reset,
  acc_seq_if.master bus
);
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_RDI, S_IR, S_ADDR, S_RDO, S_EX, S_WR0, S_WR1, S_BR, S_HALT
  } state_t;
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);
  state_t state, next;
  logic [OP_W-1:0] op_q;
  logic is_br;
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      state <= next;
      if (state == S_ADDR) op_q <= bus.op;
    end
  assign is_br = bus.op == OP_BNE || bus.op == OP_JMP;
  always_comb begin
    next = S_RST;
    case (state)
      S_RST:   next = S_FETCH;
      S_FETCH: next = S_RDI;
      S_RDI:   next = bus.mem_ready ? S_IR : S_RDI;
      S_IR:    next = S_ADDR;
      S_ADDR:  next = bus.op == OP_STORE ? S_WR0 :
                      bus.op == OP_JMP   ? S_BR :
                      bus.op == OP_BNE   ? (bus.z_flag ? S_FETCH : S_BR) :
                      bus.op == OP_HALT  ? S_HALT : S_RDO;
      S_RDO:   next = bus.mem_ready ? S_EX : S_RDO;
      S_EX:    next = S_FETCH;
      S_WR0:   next = S_WR1;
      S_WR1:   next = S_FETCH;
      S_BR:    next = S_FETCH;
      S_HALT:  next = S_HALT;
      default: next = S_RST;
    endcase
  end
  // S_ADDR drives the operand address except for branches, whose target goes out in S_BR
  assign bus.PC_bus   = state == S_FETCH;
  assign bus.ACC_bus  = state == S_WR0;
  assign bus.MDR_bus  = state == S_IR || state == S_EX;
  assign bus.Addr_bus = (state == S_ADDR && !is_br) || state == S_BR;
  assign bus.load_PC  = state == S_FETCH || state == S_BR;
  assign bus.INC_PC   = state == S_FETCH;
  assign bus.load_IR  = state == S_IR;
  assign bus.load_MAR = state == S_FETCH || (state == S_ADDR && !is_br);
  assign bus.load_MDR = state == S_RDI || state == S_RDO || state == S_WR0;
  assign bus.load_ACC = state == S_EX;
  assign bus.ALU_add  = state == S_EX && op_q == OP_ADD;
  assign bus.ALU_sub  = state == S_EX && op_q == OP_SUB;
  assign bus.ALU_xor  = state == S_EX && op_q == OP_XOR;
  assign bus.ALU_ACC  = bus.ALU_add || bus.ALU_sub || bus.ALU_xor;
  assign bus.CS       = state == S_RDI || state == S_RDO || state == S_WR1;
  assign bus.R_NW     = state != S_RST && state != S_WR1;
  assign bus.halted   = state == S_HALT;
endmodule
